// File: rtl/fifo_pkg.sv
// Shared helpers and defaults for the programmable synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    // Bits needed to hold an occupancy count of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Advance a pointer, wrapping by comparison so any depth works.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bundle for sync_fifo_prog.
// Handshake: a write is taken on any clock edge where wr_en is high and the
// FIFO has room (or a read frees a slot in the same cycle); wr_ack reports it
// one cycle later, overflow reports a refused write. A read is taken when
// rd_en is high and the FIFO is not empty; underflow reports a refused read.
interface sync_fifo_prog_if
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
);
    localparam int CW = cnt_w(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [CW-1:0]         af_level;
    logic [CW-1:0]         ae_level;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CW-1:0]         count;

    modport master (
        output data_in, wr_en, rd_en, af_level, ae_level,
        input  data_out, wr_ack, overflow, underflow, full, empty,
               almostfull, almostempty, count
    );

    modport slave (
        input  data_in, wr_en, rd_en, af_level, ae_level,
        output data_out, wr_ack, overflow, underflow, full, empty,
               almostfull, almostempty, count
    );
endinterface

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read.
module fifo_mem #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(FIFO_DEPTH)-1:0] waddr,
    input  logic [FIFO_WIDTH-1:0]         wdata,
    input  logic [$clog2(FIFO_DEPTH)-1:0] raddr,
    output logic [FIFO_WIDTH-1:0]         rdata
);
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    // Contents are deliberately not reset; pointers guard against stale reads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_prog.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count and optional first-word-fall-through output.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int FWFT       = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    sync_fifo_prog_if.slave bus
);
    localparam int            CW      = cnt_w(FIFO_DEPTH);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [FIFO_WIDTH-1:0] mem_rdata;
    logic                  wr_ack_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full;
    logic                  empty;
    logic                  rd_accept;
    logic                  wr_accept;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A read that frees a slot lets a write into a full FIFO in the same cycle.
    assign rd_accept = bus.rd_en && !empty;
    assign wr_accept = bus.wr_en && (!full || rd_accept);

    // Writes are suppressed while reset is held so the reset cycle is inert.
    fifo_mem #(
        .FIFO_WIDTH(FIFO_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_accept && rst_n),
        .waddr(wr_ptr),
        .wdata(bus.data_in),
        .raddr(rd_ptr),
        .rdata(mem_rdata)
    );

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= AW'(ptr_inc(int'(wr_ptr), FIFO_DEPTH));
            end
            if (rd_accept) begin
                rd_ptr <= AW'(ptr_inc(int'(rd_ptr), FIFO_DEPTH));
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // One-cycle status pulses describing what happened to this cycle's requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ack_q    <= wr_accept;
            overflow_q  <= bus.wr_en && !wr_accept;
            underflow_q <= bus.rd_en && !rd_accept;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q;

            // Registered read data; holds its last value when no read is taken.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else if (rd_accept) begin
                    dout_q <= mem_rdata;
                end
            end

            assign bus.data_out = dout_q;
        end else begin : g_fwft
            // Head of queue falls through; zero when nothing valid is stored.
            assign bus.data_out = empty ? '0 : mem_rdata;
        end
    endgenerate

    assign bus.wr_ack      = wr_ack_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.count       = count;
    // Thresholds beyond the depth (or zero for almost-empty) disable the flags naturally.
    assign bus.almostfull  = (count >= bus.af_level);
    assign bus.almostempty = (count <= bus.ae_level) && !empty;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: directed table, randomized run
// against a queue model, wrap-around on depth 6, and FWFT/reset sequences.
module tb_sync_fifo_prog;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst0_n = 1'b0;
    logic rst6_n = 1'b0;
    logic rstf_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) b0 ();
    sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(6)) b6 ();
    sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) bf ();

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .bus(b0.slave));
    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .FWFT(0)) dut6 (
        .clk(clk), .rst_n(rst6_n), .bus(b6.slave));
    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) dutf (
        .clk(clk), .rst_n(rstf_n), .bus(bf.slave));

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp6_q[$];

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive0(input logic wr, input logic rd, input logic [15:0] din);
        b0.wr_en = wr; b0.rd_en = rd; b0.data_in = din;
    endtask

    task automatic drive6(input logic wr, input logic rd, input logic [15:0] din);
        b6.wr_en = wr; b6.rd_en = rd; b6.data_in = din;
    endtask

    task automatic drivef(input logic wr, input logic rd, input logic [15:0] din);
        bf.wr_en = wr; bf.rd_en = rd; bf.data_in = din;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        wr, rd;
        logic [15:0] din;
        logic [3:0]  cnt;
        logic        full, empty, af, ae, ack, ovf, udf;
        logic [15:0] dout;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic wr, input logic rd, input logic [15:0] din,
                       input logic [3:0] cnt, input logic full, input logic empty,
                       input logic af, input logic ae, input logic ack,
                       input logic ovf, input logic udf, input logic [15:0] dout);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt; v.full = full;
        v.empty = empty; v.af = af; v.ae = ae; v.ack = ack; v.ovf = ovf;
        v.udf = udf; v.dout = dout;
        vt.push_back(v);
    endtask

    task automatic check0(input string tag, input int i, input logic [3:0] cnt,
                          input logic full, input logic empty, input logic af,
                          input logic ae, input logic ack, input logic ovf,
                          input logic udf, input logic [15:0] dout);
        check({tag, "_count"}, i, 32'(b0.count), 32'(cnt));
        check({tag, "_full"}, i, 32'(b0.full), 32'(full));
        check({tag, "_empty"}, i, 32'(b0.empty), 32'(empty));
        check({tag, "_almostfull"}, i, 32'(b0.almostfull), 32'(af));
        check({tag, "_almostempty"}, i, 32'(b0.almostempty), 32'(ae));
        check({tag, "_wr_ack"}, i, 32'(b0.wr_ack), 32'(ack));
        check({tag, "_overflow"}, i, 32'(b0.overflow), 32'(ovf));
        check({tag, "_underflow"}, i, 32'(b0.underflow), 32'(udf));
        check({tag, "_data_out"}, i, 32'(b0.data_out), 32'(dout));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] e_dout, din, w;
        logic        wr, rd, rd_ok, wr_ok, e_ack, e_ovf, e_udf, do_rst;
        int          wr_bias, sz;

        drive0(0, 0, 0); drive6(0, 0, 0); drivef(0, 0, 0);
        b0.af_level = 4'd0; b0.ae_level = 4'd0;
        b6.af_level = 3'd7; b6.ae_level = 3'd0;
        bf.af_level = 4'd9; bf.ae_level = 4'd0;

        // Reset state, including af_level == 0 forcing almostfull during reset.
        drive0(1, 1, 16'hFFFF);
        tick(); tick();
        check0("reset_af0", 0, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0000);
        b0.af_level = 4'd6; b0.ae_level = 4'd2;
        #1;
        check0("reset_af6", 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
        drive0(0, 0, 0);
        rst0_n = 1'b1;
        tick();
        check0("idle", 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000);

        //  wr rd din        cnt fu em af ae ack ovf udf dout
        add(1, 0, 16'h0001, 1, 0, 0, 0, 1, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0002, 2, 0, 0, 0, 1, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0003, 3, 0, 0, 0, 0, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0004, 4, 0, 0, 0, 0, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0005, 5, 0, 0, 0, 0, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0006, 6, 0, 0, 1, 0, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0007, 7, 0, 0, 1, 0, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0008, 8, 1, 0, 1, 0, 1, 0, 0, 16'h0000);
        add(1, 0, 16'h0009, 8, 1, 0, 1, 0, 0, 1, 0, 16'h0000);
        add(1, 1, 16'h00AA, 8, 1, 0, 1, 0, 1, 0, 0, 16'h0001);
        add(0, 1, 16'h0000, 7, 0, 0, 1, 0, 0, 0, 0, 16'h0002);
        add(0, 1, 16'h0000, 6, 0, 0, 1, 0, 0, 0, 0, 16'h0003);
        add(0, 1, 16'h0000, 5, 0, 0, 0, 0, 0, 0, 0, 16'h0004);
        add(0, 1, 16'h0000, 4, 0, 0, 0, 0, 0, 0, 0, 16'h0005);
        add(0, 1, 16'h0000, 3, 0, 0, 0, 0, 0, 0, 0, 16'h0006);
        add(0, 1, 16'h0000, 2, 0, 0, 0, 1, 0, 0, 0, 16'h0007);
        add(0, 1, 16'h0000, 1, 0, 0, 0, 1, 0, 0, 0, 16'h0008);
        add(0, 1, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 0, 16'h00AA);
        add(0, 1, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 1, 16'h00AA);
        add(1, 1, 16'h1234, 1, 0, 0, 0, 1, 1, 0, 1, 16'h00AA);
        add(0, 1, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 0, 16'h1234);
        add(0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 0, 16'h1234);

        foreach (vt[i]) begin
            drive0(vt[i].wr, vt[i].rd, vt[i].din);
            tick();
            check0("vec", i, vt[i].cnt, vt[i].full, vt[i].empty, vt[i].af,
                   vt[i].ae, vt[i].ack, vt[i].ovf, vt[i].udf, vt[i].dout);
        end

        // Randomized run against the queue model, with occasional resets.
        drive0(0, 0, 0);
        rst0_n = 1'b0;
        tick();
        rst0_n = 1'b1;
        exp_q.delete();
        e_dout = 16'h0000;
        wr_bias = 2;
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) begin
                wr_bias = $urandom_range(1, 3);
                b0.af_level = 4'($urandom_range(0, 9));
                b0.ae_level = 4'($urandom_range(0, 8));
            end
            wr = ($urandom_range(0, 3) < wr_bias);
            rd = ($urandom_range(0, 3) < (4 - wr_bias));
            din = 16'($urandom);
            do_rst = ($urandom_range(0, 79) == 0);
            drive0(wr, rd, din);
            rst0_n = !do_rst;
            if (do_rst) begin
                exp_q.delete();
                e_dout = 16'h0000;
                e_ack = 0; e_ovf = 0; e_udf = 0;
            end else begin
                rd_ok = rd && (exp_q.size() > 0);
                wr_ok = wr && ((exp_q.size() < 8) || rd_ok);
                e_ack = wr_ok;
                e_ovf = wr && !wr_ok;
                e_udf = rd && !rd_ok;
                if (rd_ok) e_dout = exp_q.pop_front();
                if (wr_ok) exp_q.push_back(din);
            end
            tick();
            sz = exp_q.size();
            check0("rand", c, 4'(sz), sz == 8, sz == 0, sz >= int'(b0.af_level),
                   (sz <= int'(b0.ae_level)) && (sz != 0), e_ack, e_ovf, e_udf, e_dout);
        end
        rst0_n = 1'b1;
        drive0(0, 0, 0);

        // Wrap-around on a non power-of-two depth.
        drive6(0, 0, 0);
        tick();
        rst6_n = 1'b1;
        exp6_q.delete();
        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom);
            drive6(1, 0, w);
            exp6_q.push_back(w);
            tick();
        end
        check("wrap_prefill_count", 0, 32'(b6.count), 32'd4);
        for (int i = 0; i < 20; i++) begin
            w = 16'($urandom);
            drive6(1, 0, w);
            exp6_q.push_back(w);
            tick();
            check("wrap_count_w", i, 32'(b6.count), 32'(exp6_q.size()));
            drive6(0, 1, 0);
            tick();
            check("wrap_data", i, 32'(b6.data_out), 32'(exp6_q.pop_front()));
            check("wrap_count_r", i, 32'(b6.count), 32'(exp6_q.size()));
        end
        for (int i = 0; i < 4; i++) begin
            drive6(0, 1, 0);
            tick();
            check("wrap_drain", i, 32'(b6.data_out), 32'(exp6_q.pop_front()));
        end
        check("wrap_empty", 0, 32'(b6.empty), 32'd1);
        drive6(0, 0, 0);

        // FWFT behaviour and mid-operation reset.
        tick();
        check("fwft_reset_dout", 0, 32'(bf.data_out), 32'h0);
        check("fwft_reset_empty", 0, 32'(bf.empty), 32'd1);
        rstf_n = 1'b1;
        drivef(1, 0, 16'hBEEF);
        tick();
        check("fwft_fallthrough", 0, 32'(bf.data_out), 32'hBEEF);
        check("fwft_count1", 0, 32'(bf.count), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            drivef(1, 0, 16'(i));
            tick();
        end
        drivef(0, 0, 0);
        #1;
        check("fwft_count5", 0, 32'(bf.count), 32'd5);
        check("fwft_head", 0, 32'(bf.data_out), 32'hBEEF);
        drivef(0, 1, 0);
        tick();
        check("fwft_advance", 0, 32'(bf.data_out), 32'h0001);
        check("fwft_count4", 0, 32'(bf.count), 32'd4);
        drivef(1, 0, 16'h0005);
        tick();
        check("fwft_count5b", 0, 32'(bf.count), 32'd5);
        drivef(1, 1, 16'h7777);
        rstf_n = 1'b0;
        tick();
        check("midrst_count", 0, 32'(bf.count), 32'd0);
        check("midrst_empty", 0, 32'(bf.empty), 32'd1);
        check("midrst_dout", 0, 32'(bf.data_out), 32'h0);
        check("midrst_ack", 0, 32'(bf.wr_ack), 32'd0);
        check("midrst_udf", 0, 32'(bf.underflow), 32'd0);
        rstf_n = 1'b1;
        drivef(0, 0, 0);
        tick();
        check("postrst_count", 0, 32'(bf.count), 32'd0);
        check("postrst_dout", 0, 32'(bf.data_out), 32'h0);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
